// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the RAM controller FSM state type.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;

    localparam logic [2:0] HSIZE_BYTE    = 3'd0;
    localparam logic [2:0] HSIZE_HALF    = 3'd1;
    localparam logic [2:0] HSIZE_WORD    = 3'd2;
    localparam logic [2:0] HSIZE_DWORD   = 3'd3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,
        ST_RD   = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_t;

endpackage

// File: rtl/ahb_ram_be_gen.sv
// Byte-enable and transfer-error decode for one AHB address phase.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of hsize and byte offset.
//
// Ports:
//   hsize  - AHB transfer size (log2 of byte count)
//   offset - byte offset of haddr within one bus word
//   be     - byte enables, little-endian lanes; all zero on error
//   err    - transfer wider than the bus or not naturally aligned
module ahb_ram_be_gen #(
    parameter int BW = 4
) (
    input  logic [2:0]             hsize,
    input  logic [$clog2(BW)-1:0]  offset,
    output logic [BW-1:0]          be,
    output logic                   err
);

    localparam int OFF_W = $clog2(BW);

    // hsize tops out at 7, so the byte count (128) still fits in 8 bits.
    logic [7:0] nbytes;

    always_comb begin
        nbytes = 8'd1 << hsize;
        err    = (hsize > 3'(OFF_W)) || ((8'(offset) & (nbytes - 8'd1)) != 8'd0);
        be     = '0;
        if (!err) begin
            for (int i = 0; i < BW; i++) begin
                be[i] = (i >= int'(offset)) && (i < int'(offset) + int'(nbytes));
            end
        end
    end

endmodule

// File: rtl/ahb_ram_ctrl.sv
// AHB-Lite slave bridging the bus to a single-port synchronous RAM.
// Latency: write data phase 1 cycle, read RD_LAT+1 cycles, error response 2 cycles.
// Backpressure: hready_out low during read wait states and the first error cycle.
//
// Ports:
//   hclk, hresetn            - clock, async active-low reset
//   hsel/haddr/htrans/hsize/hwrite/hready_in - AHB address phase
//   hwdata                   - AHB write data (data phase)
//   hready_out/hresp/hrdata  - AHB slave response
//   ram_en/ram_we/ram_be/ram_addr/ram_wdata - RAM request, one access per cycle max
//   ram_rdata                - RAM read data, valid RD_LAT cycles after a read strobe
module ahb_ram_ctrl
    import ahb_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 18,
    parameter int HADDR_W = 32,
    parameter int RD_LAT  = 1
) (
    input  logic                 hclk,
    input  logic                 hresetn,
    input  logic                 hsel,
    input  logic [HADDR_W-1:0]   haddr,
    input  logic [1:0]           htrans,
    input  logic [2:0]           hsize,
    input  logic                 hwrite,
    input  logic [DATA_W-1:0]    hwdata,
    input  logic                 hready_in,
    output logic                 hready_out,
    output logic [1:0]           hresp,
    output logic [DATA_W-1:0]    hrdata,
    output logic                 ram_en,
    output logic                 ram_we,
    output logic [DATA_W/8-1:0]  ram_be,
    output logic [ADDR_W-1:0]    ram_addr,
    output logic [DATA_W-1:0]    ram_wdata,
    input  logic [DATA_W-1:0]    ram_rdata
);

    localparam int         BW      = DATA_W / 8;
    localparam int         OFF_W   = $clog2(BW);
    localparam logic [2:0] RD_LAST = 3'(RD_LAT);

    // Address-phase information carried into the data phase.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [BW-1:0]     be;
    } req_t;

    state_t     state, state_nxt;
    logic [2:0] rd_cnt, rd_cnt_nxt;
    req_t       req_q, req_d;

    logic          accept;
    logic          phase_done;
    logic [BW-1:0] be_d;
    logic          err_d;

    // Upper haddr bits alias the RAM; htrans[0] does not affect acceptance.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{haddr, htrans[0]};

    ahb_ram_be_gen #(.BW(BW)) u_be_gen (
        .hsize  (hsize),
        .offset (haddr[OFF_W-1:0]),
        .be     (be_d),
        .err    (err_d)
    );

    assign accept = hsel & (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ) & hready_in;
    assign req_d  = '{addr: haddr[OFF_W+ADDR_W-1:OFF_W], be: be_d};

    // Last cycle of the current data phase: a new address phase may be taken.
    assign phase_done = !((state == ST_RD && rd_cnt != RD_LAST) || state == ST_ERR1);

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state  <= ST_IDLE;
            rd_cnt <= '0;
            req_q  <= '0;
        end else begin
            state  <= state_nxt;
            rd_cnt <= rd_cnt_nxt;
            if (phase_done && accept) begin
                req_q <= req_d;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        rd_cnt_nxt = rd_cnt;
        if (phase_done) begin
            rd_cnt_nxt = '0;
            if (!accept)     state_nxt = ST_IDLE;
            else if (err_d)  state_nxt = ST_ERR1;
            else if (hwrite) state_nxt = ST_WR;
            else             state_nxt = ST_RD;
        end else if (state == ST_ERR1) begin
            state_nxt = ST_ERR2;
        end else begin
            rd_cnt_nxt = rd_cnt + 3'd1;
        end
    end

    always_comb begin
        hready_out = phase_done;
        hresp      = HRESP_OKAY;
        hrdata     = '0;
        ram_en     = 1'b0;
        ram_we     = 1'b0;
        ram_be     = '0;
        ram_addr   = '0;
        ram_wdata  = '0;
        case (state)
            ST_WR: begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_be    = req_q.be;
                ram_addr  = req_q.addr;
                ram_wdata = hwdata;
            end
            ST_RD: begin
                // Strobe once at the start; the RAM answers RD_LAT cycles later.
                if (rd_cnt == 3'd0) begin
                    ram_en   = 1'b1;
                    ram_addr = req_q.addr;
                end
                if (rd_cnt == RD_LAST) begin
                    hrdata = ram_rdata;
                end
            end
            ST_ERR1, ST_ERR2: hresp = HRESP_ERROR;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ahb_ram_ctrl.sv
module tb_ahb_ram_ctrl;
    import ahb_pkg::*;

    localparam int RD_LAT = 2;

    logic hclk = 1'b0;
    logic hresetn = 1'b0;
    always #5 hclk = ~hclk;

    // Shared address-phase bus.
    logic        hsel32, hsel64;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic        hwrite;
    logic [31:0] hwdata32;
    logic [63:0] hwdata64;

    // 32-bit instance
    logic        rdy32;
    logic [1:0]  resp32;
    logic [31:0] rdata32;
    logic        en32, we32;
    logic [3:0]  be32;
    logic [7:0]  addr32;
    logic [31:0] wdata32;
    logic [31:0] ram_rdata32;

    // 64-bit instance
    logic        rdy64;
    logic [1:0]  resp64;
    logic [63:0] rdata64;
    logic        en64, we64;
    logic [7:0]  be64;
    logic [7:0]  addr64;
    logic [63:0] wdata64;
    logic [63:0] ram_rdata64;
    assign ram_rdata64 = 64'h0;

    ahb_ram_ctrl #(.DATA_W(32), .ADDR_W(8), .HADDR_W(32), .RD_LAT(RD_LAT)) u_dut (
        .hclk(hclk), .hresetn(hresetn), .hsel(hsel32), .haddr(haddr), .htrans(htrans),
        .hsize(hsize), .hwrite(hwrite), .hwdata(hwdata32), .hready_in(rdy32),
        .hready_out(rdy32), .hresp(resp32), .hrdata(rdata32), .ram_en(en32), .ram_we(we32),
        .ram_be(be32), .ram_addr(addr32), .ram_wdata(wdata32), .ram_rdata(ram_rdata32)
    );

    ahb_ram_ctrl #(.DATA_W(64), .ADDR_W(8), .HADDR_W(32), .RD_LAT(1)) u_dut64 (
        .hclk(hclk), .hresetn(hresetn), .hsel(hsel64), .haddr(haddr), .htrans(htrans),
        .hsize(hsize), .hwrite(hwrite), .hwdata(hwdata64), .hready_in(rdy64),
        .hready_out(rdy64), .hresp(resp64), .hrdata(rdata64), .ram_en(en64), .ram_we(we64),
        .ram_be(be64), .ram_addr(addr64), .ram_wdata(wdata64), .ram_rdata(ram_rdata64)
    );

    // RAM behavioural model with RD_LAT-cycle read pipeline.
    logic [31:0] mem [256];
    logic [31:0] rpipe [RD_LAT];
    always @(posedge hclk) begin
        if (en32 && we32) begin
            for (int i = 0; i < 4; i++) begin
                if (be32[i]) mem[addr32][8*i +: 8] <= wdata32[8*i +: 8];
            end
        end
        rpipe[0] <= (en32 && !we32) ? mem[addr32] : 32'h0;
        for (int i = 1; i < RD_LAT; i++) rpipe[i] <= rpipe[i-1];
    end
    assign ram_rdata32 = rpipe[RD_LAT-1];

    typedef struct packed {
        logic [15:0] id;
        logic        d64;
        logic        rdy;
        logic [1:0]  resp;
        logic        en;
        logic        we;
        logic [7:0]  be;
        logic [7:0]  addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        logic [63:0] rmask;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   step_id  = 0;

    function automatic exp_t ex(logic rdy, logic [1:0] resp, logic en, logic we,
                                logic [7:0] be, logic [7:0] addr,
                                logic [63:0] wd, logic [63:0] rd);
        exp_t e;
        e.id = '0; e.d64 = 1'b0; e.rdy = rdy; e.resp = resp; e.en = en; e.we = we;
        e.be = be; e.addr = addr; e.wdata = wd; e.rdata = rd; e.rmask = '1;
        return e;
    endfunction

    function automatic exp_t e_idle();             return ex(1, HRESP_OKAY, 0, 0, 0, 0, 0, 0);           endfunction
    function automatic exp_t e_wr(logic [7:0] be, logic [7:0] a, logic [63:0] d);
        return ex(1, HRESP_OKAY, 1, 1, be, a, d, 0);
    endfunction
    function automatic exp_t e_rd0(logic [7:0] a); return ex(0, HRESP_OKAY, 1, 0, 0, a, 0, 0);           endfunction
    function automatic exp_t e_rdw();              return ex(0, HRESP_OKAY, 0, 0, 0, 0, 0, 0);           endfunction
    function automatic exp_t e_rdd(logic [63:0] d); return ex(1, HRESP_OKAY, 0, 0, 0, 0, 0, d);          endfunction
    function automatic exp_t e_err1();             return ex(0, HRESP_ERROR, 0, 0, 0, 0, 0, 0);          endfunction
    function automatic exp_t e_err2();             return ex(1, HRESP_ERROR, 0, 0, 0, 0, 0, 0);          endfunction

    // One bus cycle: drive the address phase (and data-phase hwdata), and
    // queue what the DUT must show during this cycle.
    task automatic step(input logic rst_n, input logic [1:0] sel, input logic [31:0] a,
                        input logic [1:0] tr, input logic [2:0] sz, input logic wr,
                        input logic [63:0] wd, input exp_t e, input logic d64);
        @(posedge hclk);
        #1;
        hresetn  = rst_n;
        hsel32   = sel[0];
        hsel64   = sel[1];
        haddr    = a;
        htrans   = tr;
        hsize    = sz;
        hwrite   = wr;
        hwdata32 = wd[31:0];
        hwdata64 = wd;
        e.id     = 16'(step_id);
        e.d64    = d64;
        step_id++;
        q.push_back(e);
    endtask

    // Monitor: pops one expectation per cycle and compares.
    exp_t        m_e;
    logic        a_rdy, a_en, a_we;
    logic [1:0]  a_resp;
    logic [7:0]  a_be, a_addr;
    logic [63:0] a_wd, a_rd;
    always @(negedge hclk) begin
        if (q.size() > 0) begin
            m_e = q.pop_front();
            if (m_e.d64) begin
                a_rdy = rdy64; a_resp = resp64; a_en = en64; a_we = we64;
                a_be = be64; a_addr = addr64; a_wd = wdata64; a_rd = rdata64;
            end else begin
                a_rdy = rdy32; a_resp = resp32; a_en = en32; a_we = we32;
                a_be = {4'h0, be32}; a_addr = addr32; a_wd = {32'h0, wdata32}; a_rd = {32'h0, rdata32};
            end
            n_checks++;
            if ({a_rdy, a_resp, a_en, a_we, a_be, a_addr, a_wd, a_rd & m_e.rmask} !==
                {m_e.rdy, m_e.resp, m_e.en, m_e.we, m_e.be, m_e.addr, m_e.wdata, m_e.rdata & m_e.rmask}) begin
                n_fail++;
                $display("FAIL step%0d: got rdy=%b resp=%b en=%b we=%b be=%h addr=%h wdata=%h rdata=%h; want rdy=%b resp=%b en=%b we=%b be=%h addr=%h wdata=%h rdata=%h",
                         m_e.id, a_rdy, a_resp, a_en, a_we, a_be, a_addr, a_wd, a_rd & m_e.rmask,
                         m_e.rdy, m_e.resp, m_e.en, m_e.we, m_e.be, m_e.addr, m_e.wdata, m_e.rdata & m_e.rmask);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, required completion before 200000");
        $fatal(1, "watchdog");
    end

    localparam logic [1:0] S32 = 2'b01;
    localparam logic [1:0] S64 = 2'b10;
    localparam logic [1:0] S0  = 2'b00;

    initial begin
        hsel32 = 0; hsel64 = 0; haddr = 0; htrans = HTRANS_IDLE; hsize = 0;
        hwrite = 0; hwdata32 = 0; hwdata64 = 0;
        @(posedge hclk);

        // Reset values while held in reset.
        step(0, S0,  32'h0,  HTRANS_IDLE,   HSIZE_WORD, 0, 64'h0, e_idle(), 0);
        // Word write then word read of 0x10.
        step(1, S32, 32'h10, HTRANS_NONSEQ, HSIZE_WORD, 1, 64'h0, e_idle(), 0);
        step(1, S32, 32'h10, HTRANS_NONSEQ, HSIZE_WORD, 0, 64'hDEADBEEF, e_wr(8'h0F, 8'h04, 64'hDEADBEEF), 0);
        // Address phase during a wait state is ignored.
        step(1, S32, 32'h20, HTRANS_NONSEQ, HSIZE_WORD, 1, 64'h0, e_rd0(8'h04), 0);
        step(1, S0,  32'h0,  HTRANS_IDLE,   HSIZE_WORD, 0, 64'h0, e_rdw(), 0);
        step(1, S32, 32'h12, HTRANS_NONSEQ, HSIZE_HALF, 1, 64'h0, e_rdd(64'hDEADBEEF), 0);
        // Halfword at 0x12, byte at 0x13, read back 0x10.
        step(1, S32, 32'h13, HTRANS_NONSEQ, HSIZE_BYTE, 1, 64'h12340000, e_wr(8'h0C, 8'h04, 64'h12340000), 0);
        step(1, S32, 32'h10, HTRANS_NONSEQ, HSIZE_WORD, 0, 64'hAA000000, e_wr(8'h08, 8'h04, 64'hAA000000), 0);
        step(1, S0,  32'h0,  HTRANS_IDLE,   HSIZE_WORD, 0, 64'h0, e_rd0(8'h04), 0);
        step(1, S0,  32'h0,  HTRANS_IDLE,   HSIZE_WORD, 0, 64'h0, e_rdw(), 0);
        // Misaligned halfword at 0x11.
        step(1, S32, 32'h11, HTRANS_NONSEQ, HSIZE_HALF, 1, 64'h0, e_rdd(64'hAA34BEEF), 0);
        step(1, S32, 32'h40, HTRANS_NONSEQ, HSIZE_WORD, 1, 64'h0, e_err1(), 0);
        // Doubleword on a 32-bit bus.
        step(1, S32, 32'h10, HTRANS_NONSEQ, HSIZE_DWORD, 0, 64'h0, e_err2(), 0);
        step(1, S0,  32'h0,  HTRANS_IDLE,   HSIZE_WORD, 0, 64'h0, e_err1(), 0);
        // Burst NONSEQ/SEQ writes 0x0, 0x4, 0x8, IDLE, read 0x4.
        step(1, S32, 32'h0,  HTRANS_NONSEQ, HSIZE_WORD, 1, 64'h0, e_err2(), 0);
        step(1, S32, 32'h4,  HTRANS_SEQ,    HSIZE_WORD, 1, 64'h11111111, e_wr(8'h0F, 8'h00, 64'h11111111), 0);
        step(1, S32, 32'h8,  HTRANS_SEQ,    HSIZE_WORD, 1, 64'h22222222, e_wr(8'h0F, 8'h01, 64'h22222222), 0);
        step(1, S32, 32'h0,  HTRANS_IDLE,   HSIZE_WORD, 1, 64'h33333333, e_wr(8'h0F, 8'h02, 64'h33333333), 0);
        step(1, S32, 32'h4,  HTRANS_NONSEQ, HSIZE_WORD, 0, 64'h0, e_idle(), 0);
        step(1, S0,  32'h0,  HTRANS_IDLE,   HSIZE_WORD, 0, 64'h0, e_rd0(8'h01), 0);
        step(1, S0,  32'h0,  HTRANS_IDLE,   HSIZE_WORD, 0, 64'h0, e_rdw(), 0);
        // BUSY transfer, then an unselected NONSEQ.
        step(1, S32, 32'h0,  HTRANS_BUSY,   HSIZE_WORD, 1, 64'h0, e_rdd(64'h22222222), 0);
        step(1, S0,  32'h30, HTRANS_NONSEQ, HSIZE_WORD, 1, 64'h0, e_idle(), 0);
        // Read 0x8, reset at rd_cnt=1.
        step(1, S32, 32'h8,  HTRANS_NONSEQ, HSIZE_WORD, 0, 64'h0, e_idle(), 0);
        step(1, S0,  32'h0,  HTRANS_IDLE,   HSIZE_WORD, 0, 64'h0, e_rd0(8'h02), 0);
        step(0, S0,  32'h0,  HTRANS_IDLE,   HSIZE_WORD, 0, 64'h0, e_idle(), 0);
        step(0, S0,  32'h0,  HTRANS_IDLE,   HSIZE_WORD, 0, 64'h0, e_idle(), 0);
        // First transfer after reset: read 0x0.
        step(1, S32, 32'h0,  HTRANS_NONSEQ, HSIZE_WORD, 0, 64'h0, e_idle(), 0);
        step(1, S0,  32'h0,  HTRANS_IDLE,   HSIZE_WORD, 0, 64'h0, e_rd0(8'h00), 0);
        step(1, S0,  32'h0,  HTRANS_IDLE,   HSIZE_WORD, 0, 64'h0, e_rdw(), 0);
        step(1, S0,  32'h0,  HTRANS_IDLE,   HSIZE_WORD, 0, 64'h0, e_rdd(64'h11111111), 0);
        step(1, S0,  32'h0,  HTRANS_IDLE,   HSIZE_WORD, 0, 64'h0, e_idle(), 0);
        // 64-bit instance: doubleword write at 0x8 completes OKAY.
        step(1, S64, 32'h8,  HTRANS_NONSEQ, HSIZE_DWORD, 1, 64'h0, e_idle(), 1);
        step(1, S0,  32'h0,  HTRANS_IDLE,   HSIZE_WORD, 0, 64'h0123456789ABCDEF,
             e_wr(8'hFF, 8'h01, 64'h0123456789ABCDEF), 1);
        step(1, S0,  32'h0,  HTRANS_IDLE,   HSIZE_WORD, 0, 64'h0, e_idle(), 1);

        @(posedge hclk);
        #1;
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
